// File: rtl/cache_req_ctrl.sv
// rtl/cache_req_ctrl.sv - round-robin request sequencer for the direct-mapped cache (read refill, write-through)
// Optional hit/miss counters are enabled by defining CACHE_REQ_CTRL_PERF_CNT_EN.
module cache_req_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_hit,
  output logic                          cache_read_en,
  output logic                          cache_write_en,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic [DATA_WIDTH-1:0]         cache_write_data,
  input  logic [DATA_WIDTH-1:0]         cache_read_data,
  input  logic                          cache_hit,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [DATA_WIDTH-1:0]         mem_req_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data
`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_hits,
  output logic [31:0]                   perf_misses
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, MEM_WAIT, REFILL, WRITE, MEM_WR, RESP
  } state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        rr_ptr, id_q, grant_idx, scan_idx;
  logic [IDW:0]          scan_sum;
  logic                  grant_found, accept, hit_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q;

  // Descending scan so the last match, i.e. the closest to rr_ptr, wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (scan_sum >= (IDW + 1)'(NUM_REQ)) scan_sum = scan_sum - (IDW + 1)'(NUM_REQ);
      scan_idx = scan_sum[IDW-1:0];
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = req_we[grant_idx] ? WRITE : LOOKUP;
      LOOKUP:   state_nxt = CHECK;
      CHECK:    state_nxt = cache_hit ? RESP : MEM_RD;
      MEM_RD:   if (mem_req_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_rsp_valid) state_nxt = REFILL;
      REFILL:   state_nxt = RESP;
      WRITE:    state_nxt = MEM_WR;
      MEM_WR:   if (mem_req_ready) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // data_q carries the response payload: cleared for writes, cache data on hit, memory line on refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rr_ptr  <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          id_q    <= grant_idx;
          addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          data_q  <= '0;
          hit_q   <= 1'b0;
        end
        CHECK: if (cache_hit) begin
          data_q <= cache_read_data;
          hit_q  <= 1'b1;
        end
        MEM_WAIT: if (mem_rsp_valid) data_q <= mem_rsp_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready        = '0;
    rsp_valid        = '0;
    rsp_data         = '0;
    rsp_hit          = 1'b0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    cache_addr       = '0;
    cache_write_data = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    case (state)
      LOOKUP: begin
        cache_read_en = 1'b1;
        cache_addr    = addr_q;
      end
      REFILL: begin
        cache_write_en   = 1'b1;
        cache_addr       = addr_q;
        cache_write_data = data_q;
      end
      WRITE: begin
        cache_write_en   = 1'b1;
        cache_addr       = addr_q;
        cache_write_data = wdata_q;
      end
      MEM_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
      end
      MEM_WR: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_data        = data_q;
        rsp_hit         = hit_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state == CHECK) begin
      if (cache_hit) begin
        if (perf_hits != '1) perf_hits <= perf_hits + 32'd1;
      end else if (perf_misses != '1) begin
        perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// tb/tb_cache_req_ctrl.sv - scoreboard bench for cache_req_ctrl with behavioural cache and memory
// Perf counter checks are compiled when CACHE_REQ_CTRL_PERF_CNT_EN is defined.
module tb_cache_req_ctrl;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int N  = 2;
  localparam int MEM_LAT = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, cache_write_data, cache_read_data, mem_req_wdata, mem_rsp_data;
  logic            rsp_hit, cache_read_en, cache_write_en, cache_hit;
  logic [AW-1:0]   cache_addr, mem_req_addr;
  logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
  logic [31:0]     perf_hits, perf_misses;
`endif

  cache_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_addr(cache_addr), .cache_write_data(cache_write_data),
    .cache_read_data(cache_read_data), .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    bit            hit;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  int            grants[$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  int n_chk = 0, n_pass = 0, cyc = 0, exp_ptr = 0, xw;
  int rsp_cnt = 0, cwr_cnt = 0, hits_exp = 0, miss_exp = 0;
  logic [N-1:0]  oh;
  logic          mv_q = 0, mr_q = 0, mwe_q = 0;
  logic [AW-1:0] ma_q = '0;
  logic [DW-1:0] md_q = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
    if (a == 32'h1000) return {16{8'hA5}};
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural direct-mapped cache, registered outputs.
  logic [DW-1:0] c_data[4096];
  logic [AW-1:0] c_tag[4096];
  bit            c_v[4096];
  initial begin cache_hit = 1'b0; cache_read_data = '0; end
  always @(posedge clk) begin
    if (cache_write_en) begin
      c_data[cache_addr[15:4]] <= cache_write_data;
      c_tag[cache_addr[15:4]]  <= cache_addr;
      c_v[cache_addr[15:4]]    <= 1'b1;
    end
    if (cache_read_en) begin
      cache_hit       <= c_v[cache_addr[15:4]] && (c_tag[cache_addr[15:4]] == cache_addr);
      cache_read_data <= c_data[cache_addr[15:4]];
    end
  end

  // Backing memory: single-beat line fetch after MEM_LAT cycles.
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  initial begin mem_rsp_valid = 1'b0; mem_rsp_data = '0; end
  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    if (mem_req_valid && mem_req_ready && !mem_req_we) begin
      pend_addr <= mem_req_addr;
      pend_cnt  <= MEM_LAT;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= mem_line(pend_addr);
      end
    end
  end

  // Monitor: arbitration model, strobe checks, scoreboard push on accept and pop on response.
  always @(negedge clk) begin
    if (reset) begin
      foreach (sbq[i]) if (!sbq[i].we && !sbq[i].hit) ref_mem.delete(sbq[i].addr);
      sbq.delete();
      exp_ptr = 0; mv_q = 0; hits_exp = 0; miss_exp = 0;
    end else begin
      if (rsp_valid != '0) begin
        rsp_cnt++;
        if (sbq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = sbq.pop_front();
          oh = '0; oh[e.id] = 1'b1;
          chk("rsp_id", rsp_valid, oh);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_hit", rsp_hit, e.hit);
          if (e.hit) chk("hit_latency", cyc, e.cyc);
        end
      end
      if (cache_write_en) cwr_cnt++;
      if (cache_read_en || cache_write_en) chk("rd_wr_excl", cache_read_en && cache_write_en, 0);
      if (sbq.size() == 0) begin
        if (cache_read_en || cache_write_en || mem_req_valid) chk("strobe_unexpected", 1, 0);
      end else begin
        e = sbq[0];
        if (cache_read_en) chk("crd_addr", cache_addr, e.addr);
        if (cache_write_en) begin
          chk("cwr_addr", cache_addr, e.addr);
          chk("cwr_data", cache_write_data, e.we ? e.wdata : e.data);
        end
        if (mem_req_valid) begin
          chk("mem_we", mem_req_we, e.we);
          chk("mem_addr", mem_req_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_req_wdata, e.wdata);
        end
      end
      if (mem_req_valid && mv_q && !mr_q) begin
        chk("mem_hold_addr", {mem_req_we, mem_req_addr}, {mwe_q, ma_q});
        chk("mem_hold_data", mem_req_wdata, md_q);
      end
      mv_q = mem_req_valid; mr_q = mem_req_ready; mwe_q = mem_req_we;
      ma_q = mem_req_addr;  md_q = mem_req_wdata;
      if (req_ready != '0) begin
        xw = -1;
        for (int k = N - 1; k >= 0; k--) if (req_valid[(exp_ptr + k) % N]) xw = (exp_ptr + k) % N;
        oh = '0;
        if (xw >= 0) oh[xw] = 1'b1;
        chk("grant_onehot", req_ready, oh);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i; e.we = req_we[i];
          e.addr = req_addr[i*AW +: AW]; e.wdata = req_wdata[i*DW +: DW];
          e.cyc = cyc + 3;
          if (e.we) begin
            e.hit = 1'b0; e.data = '0; ref_mem[e.addr] = e.wdata;
          end else begin
            e.hit  = ref_mem.exists(e.addr);
            e.data = e.hit ? ref_mem[e.addr] : mem_line(e.addr);
            if (e.hit) hits_exp++; else miss_exp++;
            ref_mem[e.addr] = e.data;
          end
          sbq.push_back(e);
          grants.push_back(i);
          exp_ptr = (i + 1) % N;
        end
      end
    end
  end

  task automatic issue(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_we[id] = we; req_addr[id*AW +: AW] = a; req_wdata[id*DW +: DW] = d; req_valid[id] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      #1 got = req_ready[id];
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sbq.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain", sbq.size(), 0);
  endtask

  task automatic chk_quiet(input string t);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_rsp_valid"}, rsp_valid, 0);
    chk({t, "_strobes"}, {cache_read_en, cache_write_en, mem_req_valid, mem_req_we, rsp_hit}, 0);
    chk({t, "_addrs"}, {cache_addr, mem_req_addr}, 0);
    chk({t, "_cwdata"}, cache_write_data, 0);
    chk({t, "_mwdata"}, mem_req_wdata, 0);
    chk({t, "_rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int  c0, w0;
  bit  got;
  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_quiet("reset");
`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
    chk("reset_perf", {perf_hits, perf_misses}, 0);
`endif

    // write then read same address
    issue(0, 1'b1, 32'h40, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEEDFACE});
    drain();
    issue(0, 1'b0, 32'h40, '0);
    drain();

    // cold miss then re-read hit
    issue(0, 1'b0, 32'h1000, '0);
    drain();
    issue(0, 1'b0, 32'h1000, '0);
    drain();

    // round robin with both requesters hammering
    grants.delete();
    fork
      begin repeat (3) issue(0, 1'b0, 32'h40, '0); end
      begin repeat (3) issue(1, 1'b0, 32'h1000, '0); end
    join
    drain();
    chk("rr_count", grants.size(), 6);
    for (int i = 1; i < grants.size(); i++) chk("rr_alternate", grants[i], grants[i-1] ^ 1);

    // memory backpressure during write-through
    mem_req_ready = 1'b0;
    c0 = rsp_cnt;
    issue(1, 1'b1, 32'h80, {4{32'hCAFE_F00D}});
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin @(posedge clk); #1 got = mem_req_valid; end
    chk("mwr_seen", got, 1);
    repeat (4) @(posedge clk);
    #1 chk("bp_no_rsp_yet", rsp_cnt - c0, 0);
    mem_req_ready = 1'b1;
    drain();
    chk("bp_rsp_count", rsp_cnt - c0, 1);

    // reset while waiting on a line fetch
    issue(0, 1'b0, 32'h2000, '0);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = mem_req_valid && mem_req_ready && !mem_req_we;
    end
    chk("mrd_seen", got, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk_quiet("midreset");
    c0 = rsp_cnt; w0 = cwr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_rsp", rsp_cnt - c0, 0);
    chk("midreset_no_cwr", cwr_cnt - w0, 0);

    // served normally afterwards, plus hits/misses for the counters
    issue(0, 1'b0, 32'h2000, '0); drain();
    issue(1, 1'b0, 32'h40, '0);   drain();
    issue(0, 1'b0, 32'h1000, '0); drain();
    issue(1, 1'b0, 32'h3000, '0); drain();
    issue(0, 1'b0, 32'h3000, '0); drain();
`ifdef CACHE_REQ_CTRL_PERF_CNT_EN
    chk("perf_hits", perf_hits, hits_exp);
    chk("perf_misses", perf_misses, miss_exp);
    chk("perf_hits_3", perf_hits, 3);
    chk("perf_misses_2", perf_misses, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_req_ctrl.md
Name: cache_req_ctrl

Overview:
- Sequencing controller in front of the direct-mapped `cache` block.
- Arbitrates NUM_REQ requesters round-robin and drives the cache's read/write strobes with correct 1-cycle read latency.
- On a read miss, fetches the line from backing memory and refills the cache. Writes are write-through to memory.
- Sits between CPU-side requesters and the `cache` + memory interface.

Parameters:
- ADDR_WIDTH, 32, address width; matches cache.
- DATA_WIDTH, 128, line/data width; matches cache.
- NUM_REQ, 2, number of requesters, range 2..8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_hit  out  1  1=read served from cache; 0=miss or write.
- cache_read_en  out  1  to cache read_en.
- cache_write_en  out  1  to cache write_en.
- cache_addr  out  ADDR_WIDTH  to cache addr.
- cache_write_data  out  DATA_WIDTH  to cache write_data.
- cache_read_data  in  DATA_WIDTH  from cache read_data; registered, 1-cycle latency.
- cache_hit  in  1  from cache hit; registered, 1-cycle latency.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1=write-through, 0=line fetch.
- mem_req_addr  out  ADDR_WIDTH  memory address.
- mem_req_wdata  out  DATA_WIDTH  write-through data.
- mem_rsp_valid  in  1  fetch data valid; single beat.
- mem_rsp_data  in  DATA_WIDTH  fetched line.

Behaviour:
- Reset state: FSM in IDLE; rr_ptr=0; all outputs 0, including the captured addr/data registers.
- States: IDLE, LOOKUP, CHECK, MEM_RD, MEM_WAIT, REFILL, WRITE, MEM_WR, RESP.
- Arbitration (IDLE only):
  - Scan for valid requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first valid requester wins; req_ready[winner]=1, combinational in IDLE only.
  - On handshake: capture id, we, addr, wdata; set rr_ptr = (winner+1) mod NUM_REQ.
  - No valid requester: stay in IDLE, rr_ptr unchanged.
  - req_ready=0 in every other state.
- Read path:
  - IDLE → LOOKUP: assert cache_read_en with cache_addr=captured addr for exactly 1 cycle.
  - LOOKUP → CHECK: sample cache_hit/cache_read_data.
  - In CHECK, hit=1: latch data, rsp_hit=1, go to RESP.
  - In CHECK, hit=0: go to MEM_RD.
- Miss path:
  - MEM_RD: hold mem_req_valid=1, mem_req_we=0, mem_req_addr=addr until mem_req_ready; then go to MEM_WAIT.
  - MEM_WAIT: wait for mem_rsp_valid (unbounded); latch mem_rsp_data; go to REFILL.
  - REFILL: cache_write_en=1, cache_addr=addr, cache_write_data=fetched data for 1 cycle; rsp_hit=0; go to RESP.
- Write path:
  - WRITE: cache_write_en=1 with addr/wdata for 1 cycle.
  - MEM_WR: hold mem_req_valid=1, mem_req_we=1, addr and wdata until mem_req_ready; rsp_hit=0, rsp_data=0; go to RESP.
- RESP: rsp_valid[id]=1 for exactly 1 cycle, with rsp_data/rsp_hit; then go to IDLE. rsp_valid has no backpressure.
- Latency: a read hit accepted at cycle T gives rsp_valid at T+3. The next grant is possible at T+4.
- Signal rules:
  - cache_read_en and cache_write_en are never high simultaneously.
  - mem_req_valid, once asserted, holds with stable address and data until ready.
- mem_rsp_valid outside MEM_WAIT is ignored.
- Reset mid-operation returns to IDLE immediately. Any in-flight request is dropped and no response is issued; a late mem_rsp_valid is ignored.
- One request is in flight at a time; no pipelining.

Optional Feature:
- Macro: CACHE_REQ_CTRL_PERF_CNT_EN.
- Defined: adds output ports perf_hits (32) and perf_misses (32).
  - perf_hits increments in CHECK on hit; perf_misses increments in CHECK on miss.
  - Both saturate at 32'hFFFF_FFFF and are cleared by reset.
  - Writes are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write then read, same address:
  - Stimulus: req0 write addr=0x40, data=0xDEADBEEF_…; then req0 read 0x40.
  - Expect: cache_write_en pulse then mem write 0x40; the read gives rsp_hit=1 and the same data exactly 3 cycles after accept.
- Cold miss:
  - Stimulus: read addr=0x1000; memory returns 0xA5A5…A5 after 5 cycles.
  - Expect: mem_req_addr=0x1000, mem_req_we=0; REFILL writes 0xA5…; rsp_hit=0, rsp_data=0xA5…; a re-read then hits.
- Round-robin fairness:
  - Stimulus: req0 and req1 hold reads continuously.
  - Expect: grants alternate 0,1,0,1; rsp_valid goes only to the owning index.
- mem_req_ready backpressure:
  - Stimulus: mem_req_ready low for 4 cycles during MEM_WR.
  - Expect: mem_req_valid, addr and wdata stable throughout; exactly one rsp_valid after ready.
- Reset mid-operation:
  - Stimulus: reset asserted in MEM_WAIT; mem_rsp_valid arrives after reset.
  - Expect: all outputs 0; no rsp_valid; no cache_write_en; the next request is served normally.
- Perf counters (macro defined):
  - Stimulus: 3 hits and 2 misses.
  - Expect: perf_hits=3, perf_misses=2.
